// File: rtl/tonegen_pkg.sv
// Shared definitions for the polyphonic tone generator.
// Holds the default widths, the 1 ms tick constant for a 16 MHz clock,
// the per-voice configuration record and a helper for the voice-select width.
package tonegen_pkg;

   localparam int TONEGEN_DIV_W    = 24;
   localparam int TONEGEN_DUR_W    = 16;
   localparam int TONEGEN_TICK_1MS = 16000;

   // One voice's write payload: half-period divider and note length in ticks.
   typedef struct packed {
      logic [TONEGEN_DIV_W-1:0] divider;
      logic [TONEGEN_DUR_W-1:0] duration;
   } voice_cfg_t;

   // Voice-select width, never narrower than one bit even for a single voice.
   function automatic int chWidth(input int numCh);
      return (numCh > 1) ? $clog2(numCh) : 1;
   endfunction

endpackage

// File: rtl/tonegen_voice.sv
// One square-wave voice of the polyphonic tone generator.
// Keeps its own divider, phase counter, output level and remaining
// duration. A write always wins over a tick that lands in the same cycle.
module tonegen_voice
   import tonegen_pkg::*;
#(
   parameter int DIV_W = TONEGEN_DIV_W,
   parameter int DUR_W = TONEGEN_DUR_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_tick,
   input  logic             i_we,
   input  logic [DIV_W-1:0] i_divider,
   input  logic [DUR_W-1:0] i_duration,
   output logic             o_out,
   output logic             o_busy,
   output logic             o_done
);

   logic [DIV_W-1:0] r_divider;
   logic [DIV_W-1:0] r_phase;
   logic [DUR_W-1:0] r_remaining;
   logic             r_out;
   logic             r_busy;
   logic             r_done;

   // Load on write, otherwise run the half-period counter and count down the
   // note on each tick; the last tick silences the voice and flags done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_divider   <= '0;
         r_phase     <= '0;
         r_remaining <= '0;
         r_out       <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else if (i_we) begin
         r_divider   <= i_divider;
         r_remaining <= i_duration;
         r_phase     <= '0;
         r_out       <= 1'b0;
         r_busy      <= (i_divider != '0);
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_busy) begin
            if (i_tick && (r_remaining == DUR_W'(1))) begin
               r_divider   <= '0;
               r_phase     <= '0;
               r_remaining <= '0;
               r_out       <= 1'b0;
               r_busy      <= 1'b0;
               r_done      <= 1'b1;
            end else begin
               if (i_tick && (r_remaining != '0)) begin
                  r_remaining <= r_remaining - DUR_W'(1);
               end
               if (r_phase == r_divider) begin
                  r_phase <= '0;
                  r_out   <= ~r_out;
               end else begin
                  r_phase <= r_phase + DIV_W'(1);
               end
            end
         end
      end
   end

   assign o_out  = r_out;
   assign o_busy = r_busy;
   assign o_done = r_done;

endmodule

// File: rtl/tonegen_poly.sv
// Polyphonic speaker tone generator: NUM_CH independent square-wave voices
// sharing one duration prescaler, mixed onto a single registered speaker pin.
// Build option: define TONEGEN_PWM_MIX_EN to replace the XOR mix with a
// count-PWM mix (duty = active voices / NUM_CH per NUM_CH-cycle frame).
module tonegen_poly
   import tonegen_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int DIV_W    = TONEGEN_DIV_W,
   parameter int DUR_W    = TONEGEN_DUR_W,
   parameter int TICK_DIV = TONEGEN_TICK_1MS,
   parameter int CH_W     = chWidth(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_divider,
   input  logic [DUR_W-1:0]  cfg_duration,
   input  logic              cfg_we,
   output logic [NUM_CH-1:0] ch_busy,
   output logic [NUM_CH-1:0] done_pulse,
   output logic              speaker
);

   localparam int PRE_W = $clog2(TICK_DIV);

   logic [PRE_W-1:0]  r_presc;
   logic              w_tick;
   logic [NUM_CH-1:0] w_we;
   logic [NUM_CH-1:0] w_out;
   logic              r_speaker;

   assign w_tick = (r_presc == PRE_W'(TICK_DIV - 1));

   // Free-running duration prescaler; tick is high for its last count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + PRE_W'(1);
      end
   end

   // Each voice decodes its own write strobe; codes past the last voice match nothing.
   for (genvar g = 0; g < NUM_CH; g++) begin : gVoice
      assign w_we[g] = cfg_we && (cfg_ch == CH_W'(g));

      tonegen_voice #(
         .DIV_W (DIV_W),
         .DUR_W (DUR_W)
      ) uVoice (
         .clk        (clk),
         .rst        (rst),
         .i_tick     (w_tick),
         .i_we       (w_we[g]),
         .i_divider  (cfg_divider),
         .i_duration (cfg_duration),
         .o_out      (w_out[g]),
         .o_busy     (ch_busy[g]),
         .o_done     (done_pulse[g])
      );
   end

`ifdef TONEGEN_PWM_MIX_EN
   logic [CH_W-1:0] r_pwmCnt;
   logic [CH_W:0]   w_sum;

   // Count how many voices are currently driving high.
   always_comb begin
      w_sum = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         w_sum = w_sum + {{CH_W{1'b0}}, w_out[n]};
      end
   end

   // PWM frame counter sweeps 0..NUM_CH-1 continuously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pwmCnt <= '0;
      end else if (r_pwmCnt == CH_W'(NUM_CH - 1)) begin
         r_pwmCnt <= '0;
      end else begin
         r_pwmCnt <= r_pwmCnt + CH_W'(1);
      end
   end

   // Speaker is high for as many frame slots as there are high voices.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_speaker <= 1'b0;
      end else begin
         r_speaker <= ({1'b0, r_pwmCnt} < w_sum);
      end
   end
`else
   // Plain XOR mix of all voices; idle voices hold their output at 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_speaker <= 1'b0;
      end else begin
         r_speaker <= ^w_out;
      end
   end
`endif

   assign speaker = r_speaker;

endmodule
